// File: rtl/label_reg_ctrl_if.sv
// label_reg_ctrl_if: groups the loader/core request channels, the clear request and the register-file write port
// slave: the controller side (takes requests, drives readies, rf_* writes and status)
// master: the requester/register-file side
interface label_reg_ctrl_if #(parameter int SEL_WIDTH = 6, parameter int D_WIDTH = 12);
  logic                 ld_valid_i;
  logic [SEL_WIDTH-1:0] ld_addr_i;
  logic [D_WIDTH-1:0]   ld_data_i;
  logic                 ld_ready_o;
  logic                 cpu_valid_i;
  logic [SEL_WIDTH-1:0] cpu_addr_i;
  logic [D_WIDTH-1:0]   cpu_data_i;
  logic                 cpu_ready_o;
  logic                 clear_req_i;
  logic                 rf_wen_o;
  logic [SEL_WIDTH-1:0] rf_wa_o;
  logic [D_WIDTH-1:0]   rf_wd_o;
  logic                 busy_o;
  logic                 init_done_o;
  logic                 err_o;
  modport slave (
    input  ld_valid_i, ld_addr_i, ld_data_i, cpu_valid_i, cpu_addr_i, cpu_data_i, clear_req_i,
    output ld_ready_o, cpu_ready_o, rf_wen_o, rf_wa_o, rf_wd_o, busy_o, init_done_o, err_o
  );
  modport master (
    output ld_valid_i, ld_addr_i, ld_data_i, cpu_valid_i, cpu_addr_i, cpu_data_i, clear_req_i,
    input  ld_ready_o, cpu_ready_o, rf_wen_o, rf_wa_o, rf_wd_o, busy_o, init_done_o, err_o
  );
endinterface

// File: rtl/label_reg_ctrl.sv
// label_reg_ctrl: clears all label registers after reset or on request, then round-robins loader/core writes
// clk, reset_i (sync, active-high); bus: label_reg_ctrl_if slave modport
module label_reg_ctrl #(
  parameter int NUM_REG   = 16,
  parameter int SEL_WIDTH = 6,
  parameter int D_WIDTH   = 12
) (
  input  logic            clk,
  input  logic            reset_i,
  label_reg_ctrl_if.slave bus
);
  localparam logic [SEL_WIDTH-1:0] LAST = SEL_WIDTH'(NUM_REG - 1);
  typedef enum logic {CLEAR, ARB} state_t;
  state_t               r_state, w_state_nxt;
  logic [SEL_WIDTH-1:0] r_cnt, r_wa, w_addr;
  logic [D_WIDTH-1:0]   r_wd, w_data;
  logic                 r_wen, r_err, r_init, r_ld_pri;
  logic                 w_arb, w_ld_rdy, w_cpu_rdy, w_acc, w_oor, w_clr_last;
  // r_ld_pri: loader wins a tie; set whenever the core was the last one granted
  always_comb begin
    w_arb       = r_state == ARB && !reset_i && !bus.clear_req_i;
    w_ld_rdy    = w_arb && bus.ld_valid_i && (!bus.cpu_valid_i || r_ld_pri);
    w_cpu_rdy   = w_arb && bus.cpu_valid_i && (!bus.ld_valid_i || !r_ld_pri);
    w_acc       = w_ld_rdy || w_cpu_rdy;
    w_addr      = w_ld_rdy ? bus.ld_addr_i : bus.cpu_addr_i;
    w_data      = w_ld_rdy ? bus.ld_data_i : bus.cpu_data_i;
    w_oor       = w_addr > LAST;
    w_clr_last  = r_state == CLEAR && r_cnt == LAST;
    w_state_nxt = r_state == CLEAR ? (w_clr_last ? ARB : CLEAR) : (bus.clear_req_i ? CLEAR : ARB);
  end
  always_ff @(posedge clk) begin
    if (reset_i) r_state <= CLEAR;
    else         r_state <= w_state_nxt;
  end
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_cnt    <= '0;
      r_ld_pri <= 1'b1;
      r_wen    <= 1'b0;
      r_wa     <= '0;
      r_wd     <= '0;
      r_err    <= 1'b0;
      r_init   <= 1'b0;
    end else if (r_state == CLEAR) begin
      r_wen  <= 1'b1;
      r_wa   <= r_cnt;
      r_wd   <= '0;
      r_cnt  <= w_clr_last ? '0 : r_cnt + 1'b1;
      r_init <= r_init || w_clr_last;
    end else if (bus.clear_req_i) begin
      r_wen <= 1'b0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_wen <= w_acc && !w_oor;
      if (w_acc && !w_oor) begin
        r_wa <= w_addr;
        r_wd <= w_data;
      end
      if (w_acc) begin
        r_err    <= r_err || w_oor;
        r_ld_pri <= w_cpu_rdy;
      end
    end
  end
  assign bus.ld_ready_o  = w_ld_rdy;
  assign bus.cpu_ready_o = w_cpu_rdy;
  assign bus.rf_wen_o    = r_wen;
  assign bus.rf_wa_o     = r_wa;
  assign bus.rf_wd_o     = r_wd;
  assign bus.busy_o      = r_state == CLEAR;
  assign bus.init_done_o = r_init;
  assign bus.err_o       = r_err;
endmodule

// File: tb/tb_label_reg_ctrl.sv
// tb_label_reg_ctrl: directed self-checking bench for label_reg_ctrl
module tb_label_reg_ctrl;
  logic clk = 1'b0;
  logic reset_i;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  label_reg_ctrl_if #(.SEL_WIDTH(6), .D_WIDTH(12)) bus ();
  label_reg_ctrl #(.NUM_REG(16), .SEL_WIDTH(6), .D_WIDTH(12)) dut (
    .clk(clk), .reset_i(reset_i), .bus(bus)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic run_clear(input int n, input logic init_mid);
    for (int k = 0; k < n; k++) begin
      step();
      check("clr_wen", 32'(bus.rf_wen_o), 1);
      check("clr_wa", 32'(bus.rf_wa_o), k);
      check("clr_wd", 32'(bus.rf_wd_o), 0);
      check("clr_busy", 32'(bus.busy_o), (k < 15) ? 1 : 0);
      check("clr_init", 32'(bus.init_done_o), (k == 15) ? 1 : 32'(init_mid));
      if (k < 15) begin
        check("clr_ld_rdy", 32'(bus.ld_ready_o), 0);
        check("clr_cpu_rdy", 32'(bus.cpu_ready_o), 0);
      end
    end
  endtask
  initial begin
    reset_i = 1'b1;
    bus.ld_valid_i = 1'b1;
    bus.ld_addr_i = '0;
    bus.ld_data_i = '0;
    bus.cpu_valid_i = 1'b1;
    bus.cpu_addr_i = '0;
    bus.cpu_data_i = '0;
    bus.clear_req_i = 1'b0;
    step();
    step();
    check("rst_wen", 32'(bus.rf_wen_o), 0);
    check("rst_wa", 32'(bus.rf_wa_o), 0);
    check("rst_wd", 32'(bus.rf_wd_o), 0);
    check("rst_err", 32'(bus.err_o), 0);
    check("rst_init", 32'(bus.init_done_o), 0);
    check("rst_busy", 32'(bus.busy_o), 1);
    check("rst_ld_rdy", 32'(bus.ld_ready_o), 0);
    check("rst_cpu_rdy", 32'(bus.cpu_ready_o), 0);
    bus.ld_valid_i = 1'b0;
    bus.cpu_valid_i = 1'b0;
    reset_i = 1'b0;
    run_clear(16, 1'b0);
    bus.ld_valid_i = 1'b1;
    bus.ld_addr_i = 6'd3;
    bus.ld_data_i = 12'h1A4;
    #1;
    check("ld_rdy", 32'(bus.ld_ready_o), 1);
    check("ld_cpu_rdy", 32'(bus.cpu_ready_o), 0);
    step();
    check("ld_wen", 32'(bus.rf_wen_o), 1);
    check("ld_wa", 32'(bus.rf_wa_o), 3);
    check("ld_wd", 32'(bus.rf_wd_o), 12'h1A4);
    bus.ld_valid_i = 1'b0;
    bus.cpu_valid_i = 1'b1;
    bus.cpu_addr_i = 6'd5;
    bus.cpu_data_i = 12'h0AA;
    #1;
    check("cpu_rdy", 32'(bus.cpu_ready_o), 1);
    step();
    check("cpu_wa", 32'(bus.rf_wa_o), 5);
    check("cpu_wd", 32'(bus.rf_wd_o), 12'h0AA);
    bus.ld_valid_i = 1'b1;
    bus.ld_addr_i = 6'd1;
    bus.ld_data_i = 12'h111;
    bus.cpu_addr_i = 6'd2;
    bus.cpu_data_i = 12'h222;
    for (int j = 0; j < 4; j++) begin
      #1;
      check("rr_ld_rdy", 32'(bus.ld_ready_o), (j % 2 == 0) ? 1 : 0);
      check("rr_cpu_rdy", 32'(bus.cpu_ready_o), (j % 2 == 1) ? 1 : 0);
      step();
      check("rr_wen", 32'(bus.rf_wen_o), 1);
      check("rr_wa", 32'(bus.rf_wa_o), (j % 2 == 0) ? 1 : 2);
      check("rr_wd", 32'(bus.rf_wd_o), (j % 2 == 0) ? 32'h111 : 32'h222);
    end
    bus.ld_valid_i = 1'b0;
    bus.cpu_valid_i = 1'b0;
    step();
    check("idle_wen", 32'(bus.rf_wen_o), 0);
    check("idle_wa_hold", 32'(bus.rf_wa_o), 2);
    check("idle_wd_hold", 32'(bus.rf_wd_o), 12'h222);
    bus.cpu_valid_i = 1'b1;
    bus.cpu_addr_i = 6'd20;
    bus.cpu_data_i = 12'h055;
    #1;
    check("oor_rdy", 32'(bus.cpu_ready_o), 1);
    step();
    check("oor_wen", 32'(bus.rf_wen_o), 0);
    check("oor_err", 32'(bus.err_o), 1);
    check("oor_wa_hold", 32'(bus.rf_wa_o), 2);
    bus.cpu_valid_i = 1'b0;
    step();
    check("err_sticky", 32'(bus.err_o), 1);
    bus.clear_req_i = 1'b1;
    step();
    check("clr_err", 32'(bus.err_o), 0);
    check("clr_req_wen", 32'(bus.rf_wen_o), 0);
    check("clr_req_busy", 32'(bus.busy_o), 1);
    bus.clear_req_i = 1'b0;
    run_clear(16, 1'b1);
    bus.clear_req_i = 1'b1;
    bus.ld_valid_i = 1'b1;
    bus.ld_addr_i = 6'd4;
    bus.ld_data_i = 12'h3C3;
    #1;
    check("clr_pri_ld_rdy", 32'(bus.ld_ready_o), 0);
    step();
    check("clr_pri_wen", 32'(bus.rf_wen_o), 0);
    check("clr_pri_busy", 32'(bus.busy_o), 1);
    bus.clear_req_i = 1'b0;
    run_clear(16, 1'b1);
    check("post_clr_ld_rdy", 32'(bus.ld_ready_o), 1);
    step();
    check("post_clr_wen", 32'(bus.rf_wen_o), 1);
    check("post_clr_wa", 32'(bus.rf_wa_o), 4);
    check("post_clr_wd", 32'(bus.rf_wd_o), 12'h3C3);
    bus.ld_valid_i = 1'b0;
    bus.clear_req_i = 1'b1;
    step();
    bus.clear_req_i = 1'b0;
    run_clear(8, 1'b1);
    reset_i = 1'b1;
    step();
    check("midrst_wen", 32'(bus.rf_wen_o), 0);
    check("midrst_wa", 32'(bus.rf_wa_o), 0);
    check("midrst_init", 32'(bus.init_done_o), 0);
    check("midrst_busy", 32'(bus.busy_o), 1);
    reset_i = 1'b0;
    run_clear(16, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/label_reg_ctrl.md
LABEL_REG_CTRL -- requirements
Module: label_reg_ctrl

Interface
REQ-001 Parameters SHALL be:
- NUM_REG, default 16, number of label registers managed.
- SEL_WIDTH, default 6, register select width.
- D_WIDTH, default 12, label (instruction address) width.

REQ-002 Ports SHALL be:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- ld_valid_i  in  1  loader write request.
- ld_addr_i  in  SEL_WIDTH  loader target register.
- ld_data_i  in  D_WIDTH  loader label value.
- ld_ready_o  out  1  loader request accepted this cycle.
- cpu_valid_i  in  1  core label-set write request.
- cpu_addr_i  in  SEL_WIDTH  core target register.
- cpu_data_i  in  D_WIDTH  core label value.
- cpu_ready_o  out  1  core request accepted this cycle.
- clear_req_i  in  1  request to zero all label registers.
- rf_wen_o  out  1  register-file write enable (registered).
- rf_wa_o  out  SEL_WIDTH  register-file write address (registered).
- rf_wd_o  out  D_WIDTH  register-file write data (registered).
- busy_o  out  1  high while in CLEAR.
- init_done_o  out  1  set at the end of the first clear after reset; stays high until reset.
- err_o  out  1  sticky out-of-range address flag.

Function
REQ-003 The block SHALL have exactly two states, CLEAR and ARB.

REQ-004 In CLEAR, on each edge the block SHALL register rf_wen_o=1, rf_wa_o=cnt, rf_wd_o=0, then increment cnt.
- When cnt==NUM_REG-1 on that edge, cnt SHALL return to 0 and the state SHALL become ARB.
- A clear therefore spans exactly NUM_REG consecutive write cycles, addresses 0..NUM_REG-1 in order.

REQ-005 In CLEAR, ld_ready_o and cpu_ready_o SHALL be 0, and clear_req_i SHALL be ignored.

REQ-006 In ARB, the ready outputs SHALL be combinational from the valids, the round-robin pointer and the state.
- If only one valid is high, that requester's ready SHALL be 1.
- If both are high, only the requester not granted last SHALL get ready.
- The other ready SHALL be 0.

REQ-007 The round-robin pointer SHALL update only on an accepted transfer (valid & ready) and SHALL record which requester was granted.
- Reset SHALL make the loader win the first tie.

REQ-008 An accepted transfer in cycle t SHALL produce, at the next edge, rf_wen_o=1, rf_wa_o=addr and rf_wd_o=data of the granted requester.
- Write latency SHALL be one cycle.
- Back-to-back accepts SHALL give back-to-back writes.

REQ-009 An accepted transfer with addr >= NUM_REG SHALL be consumed (ready=1) but SHALL produce rf_wen_o=0 and set err_o=1 at the next edge.

REQ-010 err_o SHALL remain 1 until reset, or until clear_req_i is sampled high in ARB.

REQ-011 In ARB, a cycle with no accepted transfer SHALL register rf_wen_o=0; rf_wa_o and rf_wd_o SHALL hold their previous values.

REQ-012 clear_req_i sampled high in ARB SHALL take priority over both requesters.
- Both ready outputs SHALL be 0 in that cycle.
- The state SHALL become CLEAR with cnt=0.
- err_o SHALL be cleared.
- No request write SHALL be issued.

REQ-013 busy_o SHALL equal (state==CLEAR) combinationally.

REQ-014 init_done_o SHALL be set on the edge that leaves the first post-reset CLEAR and SHALL not fall on later clears.

REQ-015 Requesters SHALL hold valid, addr and data stable until ready; the block SHALL NOT buffer more than the one in-flight write.

Reset
REQ-016 While reset_i is high at an edge, the block SHALL register:
- state=CLEAR, cnt=0, round-robin pointer=loader;
- rf_wen_o=0, rf_wa_o=0, rf_wd_o=0;
- err_o=0, init_done_o=0.

REQ-017 Both ready outputs SHALL be 0 while reset_i is high.

REQ-018 Reset asserted mid-CLEAR or mid-transfer SHALL abandon the operation, and the full clear SHALL restart from address 0 after release.

Verification
REQ-019 The bench SHALL cover the following scenarios (NUM_REG=16, D_WIDTH=12):
- Release reset -> 16 consecutive writes addr 0..15 data 0, busy_o high for those 16 cycles, init_done_o rises after addr 15, first ready in the following cycle.
- Loader only, addr 3 data 0x1A4 -> ld_ready_o=1 same cycle; next cycle rf_wen_o=1, rf_wa_o=3, rf_wd_o=0x1A4.
- Both valid held for 4 cycles (ld addr 1, cpu addr 2) -> grant order loader, cpu, loader, cpu; writes to 1, 2, 1, 2 on consecutive cycles.
- cpu addr 20 data 0x055 -> cpu_ready_o=1, rf_wen_o=0 next cycle, err_o=1 and stays high; then clear_req_i -> err_o=0 and 16-cycle clear with init_done_o staying 1.
- clear_req_i and ld_valid_i high together in ARB -> ld_ready_o=0, clear runs; loader is granted in the first ARB cycle afterwards.
- reset_i pulsed for 1 cycle after clear address 7 -> clear restarts at address 0 and runs a full 16 writes; init_done_o=0 until complete.
